matrix_frame_scheduler: RTL and testbench
=========================================

Name: matrix_frame_scheduler

Overview:
Frame-level sequencer that reads a stored 8-bit grey frame from a synchronous frame-buffer RAM and replays it as vsync/href/pixel timing into the 3x3 matrix generator and Sobel/sharpen pipeline.
Guarantees continuous href within each line, a configurable horizontal blank between lines, and a trailing blank long enough for the generator's last-row extension to finish before the next frame can start.
Software or a top-level FSM triggers one frame per start pulse.

Parameters:
IMG_HDISP, 640, active pixels per line
IMG_VDISP, 480, active lines per frame
H_BLANK, 16, href-low cycles between lines (>=1)
V_LEAD, 4, cycles vsync is high before the first href
DELAY_NUM, 10, line gap used by the downstream matrix generator
TAIL_CYCLES, DELAY_NUM+IMG_HDISP+4, cycles after the last line before frame_done
ADDR_W, 19, frame-buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle frame request
base_addr_a  in  ADDR_W  frame buffer A base address
base_addr_b  in  ADDR_W  frame buffer B base address (used only with the optional feature)
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
buf_sel  out  1  buffer currently or last read (0=A, 1=B)
mem_rd_en  out  1  RAM read strobe
mem_rd_addr  out  ADDR_W  RAM read address
mem_rd_data  in  8  RAM read data, valid 1 cycle after mem_rd_en
out_vsync  out  1  frame valid to matrix generator
out_href  out  1  line valid to matrix generator
out_gray  out  8  pixel to matrix generator

Behaviour:
- Reset (asynchronous, immediate, also mid-frame): all outputs 0, state IDLE, all counters 0, buf_sel 0. Nothing resumes after reset release until a new start.
- FSM states and transitions:
  - IDLE: start=1 -> LEAD; latch the base address; set the address counter to that base.
  - LEAD: internal vs=1 for V_LEAD cycles -> LINE.
  - LINE: mem_rd_en=1 for exactly IMG_HDISP consecutive cycles; address counter +1 per read.
    - After the line, if line count < IMG_VDISP-1 -> HBLANK.
    - Otherwise -> TAIL.
  - HBLANK: rd_en=0 for H_BLANK cycles -> LINE; line count +1.
  - TAIL: vs=0, rd_en=0 for TAIL_CYCLES cycles. frame_done=1 on the last TAIL cycle; then -> IDLE.
- Internal vs is 1 in LEAD, LINE and HBLANK; 0 in IDLE and TAIL.
- Output pipeline: fixed latency of 2 cycles from the FSM.
  - out_href(t+2) = mem_rd_en(t).
  - out_vsync(t+2) = vs(t).
  - out_gray(t+2) = mem_rd_data(t+1), registered.
  - out_gray is 0 whenever out_href=0.
- busy=1 from the cycle after start is accepted through the frame_done cycle inclusive.
- start is ignored whenever state is not IDLE, including in the frame_done cycle. The earliest accepted restart is the cycle after frame_done.
- Address arithmetic: mem_rd_addr = base + pixel index, computed modulo 2^ADDR_W (wraps silently). mem_rd_addr holds its last value while rd_en=0.
- Per frame: exactly IMG_HDISP*IMG_VDISP reads and IMG_VDISP href pulses. All counters are 12-bit, except the address counter (ADDR_W) and the TAIL counter (wide enough for TAIL_CYCLES).

Optional Feature:
- Macro: SCHED_PINGPONG_EN.
- Defined:
  - Frames alternate between buffers: first frame after reset uses base_addr_a, then b, a, ...
  - buf_sel is updated at start acceptance and shows the buffer being read.
  - The toggle advances only for frames that reach frame_done. A reset mid-frame returns the selection to A.
- Undefined:
  - Always base_addr_a; base_addr_b is ignored; buf_sel is tied to 0.

Test Plan:
- Bench parameters for all scenarios: HDISP=4, VDISP=3, H_BLANK=2, V_LEAD=3, DELAY_NUM=2, TAIL_CYCLES=10, base_a=0x100.
- Basic frame: start at cycle 0 ->
  - busy high cycles 1-29;
  - rd_en high at 4-7, 10-13, 16-19;
  - addr 0x100..0x10B;
  - out_href at 6-9, 12-15, 18-21;
  - out_vsync 3-21;
  - frame_done only at cycle 29.
- Data path: RAM holds value = addr[7:0] -> out_gray sequence 0x00..0x0B, aligned with out_href; 0 outside href.
- Start while busy: pulses at cycles 5, 20 and 29 -> all ignored, single frame. A pulse at cycle 30 -> new frame with busy high from cycle 31.
- Reset mid-frame: rst_n low at cycle 12 -> all outputs 0 in the same cycle. After release, no activity until start; the next frame is a complete 12-read frame.
- Address wrap (ADDR_W=4 build, base_a=0xE) -> read addresses 0xE, 0xF, 0x0, ..., 0x9.
- SCHED_PINGPONG_EN, base_b=0x200, three frames -> bases 0x100, 0x200, 0x100; buf_sel 0, 1, 0. With the macro undefined: 0x100 every frame, buf_sel 0.

Source files
------------

// File: rtl/matrix_frame_scheduler.sv
// Replays a stored 8-bit grey frame from a synchronous RAM as vsync/href/pixel timing.
// Optional feature macro SCHED_PINGPONG_EN: alternate frames between buffers A and B.
`timescale 1ns/1ps
module matrix_frame_scheduler #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int H_BLANK     = 16,
  parameter int V_LEAD      = 4,
  parameter int DELAY_NUM   = 10,
  parameter int TAIL_CYCLES = DELAY_NUM + IMG_HDISP + 4,
  parameter int ADDR_W      = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_a,
  input  logic [ADDR_W-1:0] base_addr_b,
  output logic              busy,
  output logic              frame_done,
  output logic              buf_sel,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              out_vsync,
  output logic              out_href,
  output logic [7:0]        out_gray
);

  localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);
  localparam logic [11:0] LEAD_LAST = 12'(V_LEAD - 1);
  localparam logic [11:0] PIX_LAST  = 12'(IMG_HDISP - 1);
  localparam logic [11:0] LINE_LAST = 12'(IMG_VDISP - 1);
  localparam logic [11:0] HB_LAST   = 12'(H_BLANK - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);
  localparam logic [TAIL_W-1:0] TAIL_PRE  = TAIL_W'(TAIL_CYCLES - 2);
  localparam logic TAIL_ONE = (TAIL_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD   = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_TAIL   = 3'd4
  } state_t;

  state_t              state_q;
  logic [11:0]         cnt_q;
  logic [11:0]         pix_q;
  logic [11:0]         line_q;
  logic [TAIL_W-1:0]   tail_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                buf_sel_q;
  logic                rd_en_q;
  logic                vs_q;
  logic [ADDR_W-1:0]   sel_base;
  logic                sel_buf;
  logic                tail_end;

  assign tail_end = (state_q == S_TAIL) && (tail_q == TAIL_LAST);

`ifdef SCHED_PINGPONG_EN
  logic ping_q;

  // Buffer toggle advances only on completed frames; reset returns to buffer A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ping_q <= 1'b0;
    end else if (tail_end) begin
      ping_q <= ~ping_q;
    end
  end

  assign sel_buf  = ping_q;
  assign sel_base = ping_q ? base_addr_b : base_addr_a;
`else
  logic unused_base_b;
  assign unused_base_b = ^base_addr_b;
  assign sel_buf  = 1'b0;
  assign sel_base = base_addr_a;
`endif

  // Frame sequencer with registered strobes, address and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 12'd0;
      pix_q     <= 12'd0;
      line_q    <= 12'd0;
      tail_q    <= '0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      buf_sel_q <= 1'b0;
      rd_en_q   <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_LEAD;
            busy_q    <= 1'b1;
            vs_q      <= 1'b1;
            cnt_q     <= 12'd0;
            pix_q     <= 12'd0;
            line_q    <= 12'd0;
            addr_q    <= sel_base;
            buf_sel_q <= sel_buf;
          end
        end
        S_LEAD: begin
          if (cnt_q == LEAD_LAST) begin
            state_q   <= S_LINE;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
            addr_q    <= addr_q + ADDR_W'(1);
            pix_q     <= 12'd0;
            cnt_q     <= 12'd0;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_LINE: begin
          if (pix_q == PIX_LAST) begin
            rd_en_q <= 1'b0;
            cnt_q   <= 12'd0;
            if (line_q < LINE_LAST) begin
              state_q <= S_HBLANK;
            end else begin
              state_q <= S_TAIL;
              vs_q    <= 1'b0;
              tail_q  <= '0;
              done_q  <= TAIL_ONE;
            end
          end else begin
            pix_q     <= pix_q + 12'd1;
            rd_addr_q <= addr_q;
            addr_q    <= addr_q + ADDR_W'(1);
          end
        end
        S_HBLANK: begin
          if (cnt_q == HB_LAST) begin
            state_q   <= S_LINE;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
            addr_q    <= addr_q + ADDR_W'(1);
            pix_q     <= 12'd0;
            line_q    <= line_q + 12'd1;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_TAIL: begin
          if (tail_q == TAIL_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            tail_q <= tail_q + TAIL_W'(1);
            done_q <= (tail_q == TAIL_PRE);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          vs_q    <= 1'b0;
        end
      endcase
    end
  end

  logic       href1_d, href1_q;
  logic       vs1_d, vs1_q;
  logic       out_href_d, out_href_q;
  logic       out_vsync_d, out_vsync_q;
  logic [7:0] out_gray_d, out_gray_q;

  // Two-stage output alignment; stage one lines up with the RAM read latency
  always_comb begin
    href1_d     = rd_en_q;
    vs1_d       = vs_q;
    out_href_d  = href1_q;
    out_vsync_d = vs1_q;
    if (href1_q) begin
      out_gray_d = mem_rd_data;
    end else begin
      out_gray_d = 8'h00;
    end
  end

  // Output pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href1_q     <= 1'b0;
      vs1_q       <= 1'b0;
      out_href_q  <= 1'b0;
      out_vsync_q <= 1'b0;
      out_gray_q  <= 8'h00;
    end else begin
      href1_q     <= href1_d;
      vs1_q       <= vs1_d;
      out_href_q  <= out_href_d;
      out_vsync_q <= out_vsync_d;
      out_gray_q  <= out_gray_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign buf_sel     = buf_sel_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign out_vsync   = out_vsync_q;
  assign out_href    = out_href_q;
  assign out_gray    = out_gray_q;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Randomized bench for matrix_frame_scheduler against a cycle-position frame model.
// Expects ping-pong alternation only when SCHED_PINGPONG_EN is defined.
`timescale 1ns/1ps
module tb_matrix_frame_scheduler;

  localparam int H = 4, V = 3, HB = 2, VL = 3, DN = 2, TC = 10, AW = 19;
  localparam int N      = H * V;
  localparam int VS_END = VL + N + (V - 1) * HB;
  localparam int T_END  = VS_END + TC;
`ifdef SCHED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start_w = 1'b0;
  logic [AW-1:0] base_a = 19'h100;
  logic [AW-1:0] base_b = 19'h200;
  logic          busy, frame_done, buf_sel, mem_rd_en, out_vsync, out_href;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data = 8'h00;
  logic [7:0]    out_gray;
  logic [7:0]    ram [0:1023];

  logic       w_busy, w_done, w_bsel, w_rd_en, w_vs, w_href;
  logic [3:0] w_addr;
  logic [7:0] w_gray;
  logic [3:0] w_q [$];

  int n_chk = 0, n_fail = 0;

  // model state
  bit            m_active = 1'b0;
  int            m_fr = 0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_last = '0;
  bit            m_ping = 1'b0;
  bit            m_bsel = 1'b0;

  always #5 clk = ~clk;

  matrix_frame_scheduler #(.IMG_HDISP(H), .IMG_VDISP(V), .H_BLANK(HB), .V_LEAD(VL),
    .DELAY_NUM(DN), .TAIL_CYCLES(TC), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr_a(base_a), .base_addr_b(base_b),
    .busy(busy), .frame_done(frame_done), .buf_sel(buf_sel), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_vsync(out_vsync),
    .out_href(out_href), .out_gray(out_gray));

  matrix_frame_scheduler #(.IMG_HDISP(H), .IMG_VDISP(V), .H_BLANK(HB), .V_LEAD(VL),
    .DELAY_NUM(DN), .TAIL_CYCLES(TC), .ADDR_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .base_addr_a(4'hE), .base_addr_b(4'h0),
    .busy(w_busy), .frame_done(w_done), .buf_sel(w_bsel), .mem_rd_en(w_rd_en),
    .mem_rd_addr(w_addr), .mem_rd_data(8'h00), .out_vsync(w_vs),
    .out_href(w_href), .out_gray(w_gray));

  // synchronous frame-buffer RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position r inside a frame (1 = first cycle after start accepted) -> strobes and reads done
  function automatic void frame_at(input int r, output bit rd, output bit vs, output int nrd);
    int pos, l, p;
    rd = 1'b0; vs = 1'b0; nrd = 0;
    if (r >= 1 && r <= T_END) begin
      vs  = (r <= VS_END);
      pos = r - VL - 1;
      if (pos >= 0) begin
        l = pos / (H + HB);
        p = pos % (H + HB);
        if (l >= V) nrd = N;
        else begin
          rd  = (p < H);
          nrd = l * H + ((p < H) ? p + 1 : H);
        end
      end
    end
  endfunction

  task automatic model_edge(input bit st);
    bit was_idle;
    if (rst_n) begin
      was_idle = !m_active;
      if (m_active) begin
        m_fr++;
        if (m_fr > T_END) begin
          m_active = 1'b0;
          m_last   = m_base + AW'(N - 1);
          m_ping   = ~m_ping;
        end
      end
      if (was_idle && st) begin
        m_active = 1'b1;
        m_fr     = 1;
        m_bsel   = PP ? m_ping : 1'b0;
        m_base   = m_bsel ? base_b : base_a;
      end
    end
  endtask

  task automatic check_outputs();
    bit rd, vs, rd2, vs2, e_busy, e_done;
    int nrd, nrd2;
    logic [AW-1:0] e_addr, g_addr;
    logic [7:0] e_gray;
    rd = 0; vs = 0; rd2 = 0; vs2 = 0; nrd = 0; nrd2 = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      frame_at(m_fr, rd, vs, nrd);
      frame_at(m_fr - 2, rd2, vs2, nrd2);
      e_busy = 1'b1;
      e_done = (m_fr == T_END);
    end
    if (nrd > 0) e_addr = m_base + AW'(nrd - 1);
    else e_addr = m_last;
    g_addr = m_base + AW'(nrd2 - 1);
    e_gray = rd2 ? ram[g_addr[9:0]] : 8'h00;
    check_eq("busy", busy, e_busy);
    check_eq("frame_done", frame_done, e_done);
    check_eq("buf_sel", buf_sel, m_bsel);
    check_eq("rd_en", mem_rd_en, rd);
    check_eq("rd_addr", mem_rd_addr, e_addr);
    check_eq("vsync", out_vsync, vs2);
    check_eq("href", out_href, rd2);
    check_eq("gray", out_gray, e_gray);
    if (w_rd_en) w_q.push_back(w_addr);
  endtask

  task automatic tick(input bit st);
    start = st;
    @(posedge clk);
    model_edge(st);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_active = 1'b0; m_last = '0; m_ping = 1'b0; m_bsel = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = i[7:0];
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // basic frame with ignored starts at 5, 20, 29 and restart at 30
    for (int c = 0; c < 64; c++) begin
      start_w = (c == 0);
      tick(c == 0 || c == 5 || c == 20 || c == 29 || c == 30);
    end
    start_w = 1'b0;
    check_eq("wrap_count", w_q.size(), N);
    for (int k = 0; k < N; k++) begin
      if (k < w_q.size()) check_eq("wrap_addr", w_q[k], (14 + k) % 16);
    end

    // reset in the middle of a frame, then idle, then a full frame
    tick(1'b1);
    while (m_fr < 12) tick(1'b0);
    do_reset();
    repeat (5) tick(1'b1 == 1'b0);
    tick(1'b1);
    repeat (32) tick(1'b0);

    // three frames from reset for buffer alternation
    do_reset();
    for (int f = 0; f < 3; f++) begin
      tick(1'b1);
      repeat (31) tick(1'b0);
    end

    // randomized traffic with random RAM, bases and occasional resets
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) base_a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) base_b = AW'($urandom);
      tick($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    repeat (T_END + 3) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
